// File: rtl/i8088_bus_pkg.sv
// Shared types for the 8088 local-bus target: FSM states and the request bundle.
package i8088_bus_pkg;

    localparam int ADDR_W = 20;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        STROBE,
        REQ,
        WAIT_RSP,
        DONE
    } bus_state_t;

    typedef struct packed {
        logic              write;
        logic              io;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        wdata;
    } bus_req_t;

endpackage

// File: rtl/i8088_bus_slave_if.sv
// Bundle of the 8088 pin-side signals and the fabric request/response handshake.
interface i8088_bus_slave_if;
    import i8088_bus_pkg::*;

    logic              ale;
    logic              nrd;
    logic              nwr;
    logic              io_nm;
    logic [11:0]       a_hi;
    logic [7:0]        ad_in;
    logic [7:0]        ad_out;
    logic              ad_oe;
    logic              ready;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_io;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_wdata;
    logic              rsp_valid;
    logic [7:0]        rsp_rdata;
    logic              err;

    modport slave (
        input  ale, nrd, nwr, io_nm, a_hi, ad_in, req_ready, rsp_valid, rsp_rdata,
        output ad_out, ad_oe, ready, req_valid, req_write, req_io, req_addr, req_wdata, err
    );

    modport master (
        output ale, nrd, nwr, io_nm, a_hi, ad_in, req_ready, rsp_valid, rsp_rdata,
        input  ad_out, ad_oe, ready, req_valid, req_write, req_io, req_addr, req_wdata, err
    );

endinterface

// File: rtl/i8088_sync.sv
// N-stage, W-bit flop chain. Used both as a metastability synchroniser for the
// strobes and as a matched-delay pipe so address/data line up with them.
module i8088_sync #(
    parameter int            N         = 2,
    parameter int            W         = 1,
    parameter logic [W-1:0]  RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [N];

    // Shift the raw value through N flops; reset loads the idle level of the pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) stage[i] <= RESET_VAL;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[N-1];

endmodule

// File: rtl/i8088_bus_slave.sv
// 8088 local-bus target: turns each CPU bus cycle into one valid/ready request,
// stalls the CPU with READY until the fabric completes it, and returns read data on AD.
module i8088_bus_slave
    import i8088_bus_pkg::*;
#(
    parameter int         SYNC_STAGES    = 2,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter logic [7:0] TIMEOUT_DATA   = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    i8088_bus_slave_if.slave  bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [3:0]        strb_s;
    logic [ADDR_W-1:0] pipe_q;
    logic              ale_s, nrd_s, nwr_s, io_nm_s;

    bus_state_t        state;
    bus_req_t          req;
    logic              req_valid_r;
    logic              ready_r;
    logic [7:0]        ad_out_r;
    logic              rd_done;
    logic              err_r;
    logic [CNT_W-1:0]  cnt;

    // Strobes idle high (nRD/nWR) or low (ALE, IO/nM) out of reset.
    i8088_sync #(.N(SYNC_STAGES), .W(4), .RESET_VAL(4'b0110)) u_strb_sync (
        .clk (clk),
        .rst (rst),
        .d   ({bus.ale, bus.nrd, bus.nwr, bus.io_nm}),
        .q   (strb_s)
    );

    // Address/data delayed by the same depth so they stay aligned with the strobes.
    i8088_sync #(.N(SYNC_STAGES), .W(ADDR_W), .RESET_VAL('0)) u_data_pipe (
        .clk (clk),
        .rst (rst),
        .d   ({bus.a_hi, bus.ad_in}),
        .q   (pipe_q)
    );

    assign ale_s   = strb_s[3];
    assign nrd_s   = strb_s[2];
    assign nwr_s   = strb_s[1];
    assign io_nm_s = strb_s[0];

    // Bus-cycle sequencer: address capture, strobe decode, request handshake, completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            req         <= '0;
            req_valid_r <= 1'b0;
            ready_r     <= 1'b1;
            ad_out_r    <= 8'h00;
            rd_done     <= 1'b0;
            err_r       <= 1'b0;
            cnt         <= '0;
        end else begin
            err_r <= 1'b0;
            case (state)
                IDLE: begin
                    rd_done <= 1'b0;
                    if (ale_s) begin
                        req.addr <= pipe_q;
                        req.io   <= io_nm_s;
                        ready_r  <= 1'b0;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (ale_s) begin
                        req.addr <= pipe_q;
                        req.io   <= io_nm_s;
                    end else begin
                        state <= STROBE;
                    end
                end
                STROBE: begin
                    if (!nrd_s && !nwr_s) begin
                        err_r   <= 1'b1;
                        ready_r <= 1'b1;
                        state   <= DONE;
                    end else if (!nwr_s) begin
                        req.write   <= 1'b1;
                        req.wdata   <= pipe_q[7:0];
                        req_valid_r <= 1'b1;
                        state       <= REQ;
                    end else if (!nrd_s) begin
                        req.write   <= 1'b0;
                        req_valid_r <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (bus.req_ready) begin
                        req_valid_r <= 1'b0;
                        if (req.write) begin
                            ready_r <= 1'b1;
                            state   <= DONE;
                        end else begin
                            cnt   <= '0;
                            state <= WAIT_RSP;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (bus.rsp_valid) begin
                        ad_out_r <= bus.rsp_rdata;
                        rd_done  <= 1'b1;
                        ready_r  <= 1'b1;
                        state    <= DONE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        ad_out_r <= TIMEOUT_DATA;
                        err_r    <= 1'b1;
                        rd_done  <= 1'b1;
                        ready_r  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (nrd_s && nwr_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // READY drops combinationally on the synchronised ALE rise to save a clock of latency.
    assign bus.ready     = ready_r & ~((state == IDLE) & ale_s);
    // Raw nRD gates the driver so AD is released as soon as the CPU ends the read.
    assign bus.ad_oe     = (state == DONE) & rd_done & ~bus.nrd;
    assign bus.ad_out    = ad_out_r;
    assign bus.req_valid = req_valid_r;
    assign bus.req_write = req.write;
    assign bus.req_io    = req.io;
    assign bus.req_addr  = req.addr;
    assign bus.req_wdata = req.wdata;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_i8088_bus_slave.sv
// Self-checking bench for i8088_bus_slave: directed scenarios plus randomized bus
// cycles checked against a transaction-level expectation queue.
module tb_i8088_bus_slave;

    localparam int TIMEOUT = 4096;

    typedef struct {
        logic        write;
        logic        io;
        logic [19:0] addr;
        logic [7:0]  wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   failures = 0;
    txn_t exp_q[$];

    i8088_bus_slave_if bus();

    i8088_bus_slave #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TIMEOUT), .TIMEOUT_DATA(8'hFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Expected read byte seen by the CPU: fabric data, or the timeout filler.
    function automatic logic [7:0] model_rdata(input bit answered, input logic [7:0] d);
        return answered ? d : 8'hFF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ALE phase with address, then assert the strobe(s) for the data phase.
    task automatic applyStimulus(input txn_t t, input bit both_low);
        bus.io_nm = t.io;
        bus.a_hi  = t.addr[19:8];
        bus.ad_in = t.addr[7:0];
        bus.ale   = 1'b1;
        tick();
        tick();
        checkOutput("ready_low_after_ale", bus.ready, 0);
        bus.ale = 1'b0;
        tick();
        if (both_low) begin
            bus.ad_in = t.wdata;
            bus.nwr   = 1'b0;
            bus.nrd   = 1'b0;
        end else if (t.write) begin
            bus.ad_in = t.wdata;
            bus.nwr   = 1'b0;
        end else begin
            bus.ad_in = 8'($urandom);
            bus.nrd   = 1'b0;
        end
    endtask

    task automatic release_bus();
        bus.nrd   = 1'b1;
        bus.nwr   = 1'b1;
        bus.ale   = 1'b0;
        bus.io_nm = 1'b0;
        repeat (4) tick();
        checkOutput("ready_idle", bus.ready, 1);
    endtask

    // One full bus cycle: rsp_delay < 0 means the fabric never answers the read.
    task automatic run_txn(input txn_t t, input int acc_delay, input int rsp_delay,
                           input logic [7:0] rdata, input bit early_release);
        txn_t e;
        int   n;
        bit   ready_rose;
        logic [31:0] exp_fields;
        exp_q.push_back(t);
        applyStimulus(t, 1'b0);
        n = 0;
        while (bus.req_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("req_valid_seen", bus.req_valid, 1);
        if (bus.req_valid !== 1'b1) begin
            void'(exp_q.pop_front());
            release_bus();
            return;
        end
        e = exp_q.pop_front();
        exp_fields = {1'b1, e.write, e.io, e.addr, (e.write ? e.wdata : 8'h00)};
        checkOutput("ready_low_in_req", bus.ready, 0);
        checkOutput("req_fields", {bus.req_valid, bus.req_write, bus.req_io, bus.req_addr,
                    (e.write ? bus.req_wdata : 8'h00)}, exp_fields);
        if (early_release) begin
            bus.nrd = 1'b1;
            bus.nwr = 1'b1;
        end
        for (int i = 0; i < acc_delay; i++) begin
            tick();
            checkOutput("req_hold", {bus.req_valid, bus.req_write, bus.req_io, bus.req_addr,
                        (e.write ? bus.req_wdata : 8'h00)}, exp_fields);
        end
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready = 1'b0;
        checkOutput("req_valid_drop", bus.req_valid, 0);
        if (e.write) begin
            checkOutput("ready_after_wr_accept", bus.ready, 1);
            checkOutput("ad_oe_write", bus.ad_oe, 0);
        end else if (rsp_delay >= 0) begin
            for (int i = 0; i < rsp_delay; i++) begin
                checkOutput("ready_wait_rsp", bus.ready, 0);
                tick();
            end
            bus.rsp_valid = 1'b1;
            bus.rsp_rdata = rdata;
            tick();
            bus.rsp_valid = 1'b0;
            checkOutput("ready_after_rsp", bus.ready, 1);
            checkOutput("ad_out_rsp", bus.ad_out, model_rdata(1'b1, rdata));
            checkOutput("ad_oe_rsp", bus.ad_oe, early_release ? 0 : 1);
            checkOutput("err_rsp", bus.err, 0);
        end else begin
            n = 0;
            ready_rose = 1'b0;
            while (bus.err !== 1'b1 && n < TIMEOUT + 20) begin
                if (bus.ready !== 1'b0) ready_rose = 1'b1;
                tick();
                n++;
            end
            checkOutput("timeout_cycles", n, TIMEOUT);
            checkOutput("ready_stall_timeout", ready_rose, 0);
            checkOutput("ready_after_timeout", bus.ready, 1);
            checkOutput("ad_out_timeout", bus.ad_out, model_rdata(1'b0, rdata));
            checkOutput("ad_oe_timeout", bus.ad_oe, 1);
            tick();
            checkOutput("err_pulse_end", bus.err, 0);
        end
        if (!e.write && !early_release) begin
            bus.nrd = 1'b1;
            #1;
            checkOutput("ad_oe_nrd_release", bus.ad_oe, 0);
        end
        release_bus();
    endtask

    initial begin
        txn_t t;
        int   n;
        bit   seen_req;

        bus.ale = 1'b0; bus.nrd = 1'b1; bus.nwr = 1'b1; bus.io_nm = 1'b0;
        bus.a_hi = '0; bus.ad_in = '0; bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0; bus.rsp_rdata = '0;

        // Reset state
        repeat (3) tick();
        checkOutput("rst_ready", bus.ready, 1);
        checkOutput("rst_ad_oe", bus.ad_oe, 0);
        checkOutput("rst_ad_out", bus.ad_out, 0);
        checkOutput("rst_req", {bus.req_valid, bus.req_write, bus.req_io, bus.req_addr, bus.req_wdata}, 0);
        checkOutput("rst_err", bus.err, 0);
        rst = 1'b0;
        repeat (3) tick();

        // Memory write, then memory read answered 5 clocks after accept
        t = '{write: 1'b1, io: 1'b0, addr: 20'h20000, wdata: 8'h09};
        run_txn(t, 2, 0, 8'h00, 1'b0);
        t = '{write: 1'b0, io: 1'b0, addr: 20'h20000, wdata: 8'h00};
        run_txn(t, 0, 5, 8'h09, 1'b0);

        // Back-to-back IO writes with different addresses
        t = '{write: 1'b1, io: 1'b1, addr: 20'h00080, wdata: 8'h03};
        run_txn(t, 0, 0, 8'h00, 1'b0);
        t = '{write: 1'b1, io: 1'b1, addr: 20'h00084, wdata: 8'h05};
        run_txn(t, 1, 0, 8'h00, 1'b0);

        // Read that the fabric never answers
        t = '{write: 1'b0, io: 1'b0, addr: 20'hABCDE, wdata: 8'h00};
        run_txn(t, 0, -1, 8'h00, 1'b0);

        // Long backpressure on a write
        t = '{write: 1'b1, io: 1'b0, addr: 20'h5A5A5, wdata: 8'hC3};
        run_txn(t, 50, 0, 8'h00, 1'b0);

        // Read strobe released before the fabric answers
        t = '{write: 1'b0, io: 1'b1, addr: 20'h003F8, wdata: 8'h00};
        run_txn(t, 2, 3, 8'h77, 1'b1);

        // Both strobes low: error pulse, no request
        t = '{write: 1'b1, io: 1'b0, addr: 20'h12345, wdata: 8'h66};
        applyStimulus(t, 1'b1);
        n = 0;
        seen_req = 1'b0;
        while (bus.err !== 1'b1 && n < 20) begin
            if (bus.req_valid === 1'b1) seen_req = 1'b1;
            tick();
            n++;
        end
        checkOutput("both_low_err", bus.err, 1);
        checkOutput("both_low_ready", bus.ready, 1);
        checkOutput("both_low_no_req", seen_req | bus.req_valid, 0);
        release_bus();

        // Reset asserted while a request is pending
        t = '{write: 1'b1, io: 1'b0, addr: 20'h0F00F, wdata: 8'h11};
        applyStimulus(t, 1'b0);
        n = 0;
        while (bus.req_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("abort_req_seen", bus.req_valid, 1);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        checkOutput("abort_req_valid", bus.req_valid, 0);
        checkOutput("abort_ready", bus.ready, 1);
        bus.nwr = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        release_bus();

        // Randomized cycles against the transaction model
        for (int k = 0; k < 12; k++) begin
            t.write = 1'($urandom);
            t.io    = 1'($urandom);
            t.addr  = 20'($urandom);
            t.wdata = 8'($urandom);
            run_txn(t, int'($urandom_range(0, 4)), int'($urandom_range(0, 6)),
                    8'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
